// File: rtl/team_06_i2s_pkg.sv
// Shared types and constants for the serial-audio receiver.
package team_06_i2s_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_e;

    localparam logic CH_LEFT  = 1'b0;
    localparam logic CH_RIGHT = 1'b1;

endpackage

// File: rtl/team_06_i2s_rx_if.sv
// Output word port: captured word plus channel, valid/ready handshake.
interface team_06_i2s_rx_if #(
    parameter int DATA_W = 8
);
    logic [DATA_W-1:0] data_out;
    logic              chan_out;
    logic              valid_out;
    logic              ready_in;

    modport master (output data_out, output chan_out, output valid_out, input ready_in);
    modport slave  (input data_out, input chan_out, input valid_out, output ready_in);
endinterface

// File: rtl/team_06_i2s_rx_sck_gen.sv
// Bit-clock generator: divides clk by 2*CLK_DIV and flags the cycle in
// which sck is about to rise or fall. Held cleared while en_i is low.
module team_06_i2s_sck_gen #(
    parameter int CLK_DIV = 4
) (
    input  logic clk,
    input  logic nrst,
    input  logic en_i,
    output logic sck_o,
    output logic rise_o,
    output logic fall_o
);
    localparam int CW = $clog2(CLK_DIV + 1);

    logic [CW-1:0] cnt_q, cnt_d;
    logic          sck_q, sck_d;
    logic          tc;

    assign tc     = (cnt_q == CW'(CLK_DIV - 1));
    // Strobes mark the cycle whose closing edge moves sck.
    assign rise_o = en_i && tc && !sck_q;
    assign fall_o = en_i && tc && sck_q;
    assign sck_o  = sck_q;

    // Divider and sck next state; everything parks at 0 when disabled.
    always_comb begin
        cnt_d = '0;
        sck_d = 1'b0;
        if (en_i) begin
            cnt_d = tc ? '0 : cnt_q + CW'(1);
            sck_d = tc ? ~sck_q : sck_q;
        end
    end

    // Divider and sck registers.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            cnt_q <= '0;
            sck_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            sck_q <= sck_d;
        end
    end
endmodule

// File: rtl/team_06_i2s_rx.sv
// Serial-audio receiver: drives sck/ws to an external ADC, shifts in
// DATA_W-bit words on sck rising edges, and hands each finished word
// to a single-entry valid/ready output register with a sticky overrun.
module team_06_i2s_rx
    import team_06_i2s_pkg::*;
#(
    parameter int DATA_W    = 8,
    parameter int CLK_DIV   = 4,
    parameter int MSB_FIRST = 1,
    parameter int STEREO    = 1
) (
    input  logic             clk,
    input  logic             nrst,
    input  logic             en,
    input  logic             sd_in,
    output logic             sck_out,
    output logic             ws_out,
    team_06_i2s_rx_if.master out_if,
    output logic             overrun,
    input  logic             clr_ovr
);
    localparam int BCW = $clog2(DATA_W);

    state_e            state_q, state_d;
    logic              run, rise, fall;
    logic [BCW-1:0]    bit_q, bit_d;
    logic [DATA_W-1:0] shift_q, shift_d, shift_nx;
    logic              ws_q, ws_d;
    logic              done_q, done_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic              chan_q, chan_d;
    logic              valid_q, valid_d;
    logic              ovr_q, ovr_d;
    logic              complete, load, drop;

    // Capture only runs while in RUN with en still high, so dropping en
    // stops strobes at once and clears the capture state on the next edge.
    assign run = (state_q == RUN) && en;

    team_06_i2s_sck_gen #(.CLK_DIV(CLK_DIV)) u_sck (
        .clk    (clk),
        .nrst   (nrst),
        .en_i   (run),
        .sck_o  (sck_out),
        .rise_o (rise),
        .fall_o (fall)
    );

    // FSM state register.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) state_q <= IDLE;
        else       state_q <= state_d;
    end

    // FSM next state: RUN simply follows en.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (en)  state_d = RUN;
            RUN:     if (!en) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Shift register with the current sd_in inserted at the configured end.
    always_comb begin
        if (MSB_FIRST != 0) shift_nx = {shift_q[DATA_W-2:0], sd_in};
        else                shift_nx = {sd_in, shift_q[DATA_W-1:1]};
    end

    assign complete = rise && (bit_q == BCW'(DATA_W - 1));
    assign load     = complete && (!valid_q || out_if.ready_in);
    assign drop     = complete && valid_q && !out_if.ready_in;

    // Capture path: bit counter, shift register, ws toggle after each word.
    always_comb begin
        bit_d   = bit_q;
        shift_d = shift_q;
        ws_d    = ws_q;
        done_d  = done_q;
        if (!run) begin
            bit_d   = '0;
            shift_d = '0;
            ws_d    = CH_LEFT;
            done_d  = 1'b0;
        end else begin
            if (rise) begin
                shift_d = shift_nx;
                bit_d   = complete ? '0 : bit_q + BCW'(1);
            end
            // ws moves on the falling edge that follows a finished word,
            // so the next word's first bit is already in the new channel.
            if (complete) begin
                done_d = 1'b1;
            end else if (fall && done_q) begin
                done_d = 1'b0;
                if (STEREO != 0) ws_d = ~ws_q;
            end
        end
    end

    // Output register, handshake and sticky overrun (set beats clear).
    always_comb begin
        data_d  = data_q;
        chan_d  = chan_q;
        valid_d = valid_q;
        ovr_d   = ovr_q;
        if (load) begin
            data_d  = shift_nx;
            chan_d  = ws_q;
            valid_d = 1'b1;
        end else if (valid_q && out_if.ready_in) begin
            valid_d = 1'b0;
        end
        if (drop)         ovr_d = 1'b1;
        else if (clr_ovr) ovr_d = 1'b0;
    end

    // Datapath registers.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            bit_q   <= '0;
            shift_q <= '0;
            ws_q    <= CH_LEFT;
            done_q  <= 1'b0;
            data_q  <= '0;
            chan_q  <= CH_LEFT;
            valid_q <= 1'b0;
            ovr_q   <= 1'b0;
        end else begin
            bit_q   <= bit_d;
            shift_q <= shift_d;
            ws_q    <= ws_d;
            done_q  <= done_d;
            data_q  <= data_d;
            chan_q  <= chan_d;
            valid_q <= valid_d;
            ovr_q   <= ovr_d;
        end
    end

    assign ws_out           = ws_q;
    assign overrun          = ovr_q;
    assign out_if.data_out  = data_q;
    assign out_if.chan_out  = chan_q;
    assign out_if.valid_out = valid_q;
endmodule
